// File: rtl/rf_pkg.sv
//==============================================================================
// Package : rf_pkg
// Brief   : Shared defaults and types for the 2-read/1-write register file.
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

package rf_pkg;

    localparam int RF_WIDTH = 16;
    localparam int RF_NREGS = 8;
    localparam int RF_AW    = $clog2(RF_NREGS);

    typedef logic [RF_AW-1:0]    reg_idx_t;
    typedef logic [RF_WIDTH-1:0] word_t;

    localparam word_t RF_ZERO = '0;

endpackage

`default_nettype wire

// File: rtl/regfile_2r1w_if.sv
//==============================================================================
// Interface : regfile_2r1w_if
// Brief     : Decoder/datapath-side bundle of the register file (write, clear, 2 reads).
// Rev       : 1.0 - initial release
//==============================================================================
`default_nettype none

interface regfile_2r1w_if
    import rf_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int NREGS = RF_NREGS
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic             write;
    logic [AW-1:0]    writenum;
    logic [WIDTH-1:0] data_in;
    logic             clear;
    logic [AW-1:0]    readnum_a;
    logic [AW-1:0]    readnum_b;
    logic [WIDTH-1:0] data_out_a;
    logic [WIDTH-1:0] data_out_b;
    logic [NREGS-1:0] valid;

    modport master (
        output write, writenum, data_in, clear, readnum_a, readnum_b,
        input  data_out_a, data_out_b, valid
    );

    modport slave (
        input  write, writenum, data_in, clear, readnum_a, readnum_b,
        output data_out_a, data_out_b, valid
    );

endinterface

`default_nettype wire

// File: rtl/rf_cell.sv
//==============================================================================
// Module : rf_cell
// Brief  : WIDTH-bit enabled register, async reset, sync clear; load beats clear.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rf_cell #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_load,
    input  wire logic             i_clear,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // A write on the clear edge lands on top of the cleared file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= RESET_VALUE;
        end else if (i_load) begin
            r_q <= i_d;
        end else if (i_clear) begin
            r_q <= RESET_VALUE;
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/regfile_2r1w.sv
//==============================================================================
// Module : regfile_2r1w
// Brief  : NREGS x WIDTH register file, one write port, two read ports, bypass,
//          optional zero R0, optional registered reads, written-since-clear map.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module regfile_2r1w
    import rf_pkg::*;
#(
    parameter int               WIDTH       = RF_WIDTH,
    parameter int               NREGS       = RF_NREGS,
    parameter int               READ_LAT    = 0,
    parameter int               BYPASS      = 1,
    parameter int               ZERO_REG    = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  wire logic    clk,
    input  wire logic    reset,
    regfile_2r1w_if.slave bus
);

    localparam int            AW      = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [AW:0]   c_nregs = (AW+1)'(NREGS);

    logic [WIDTH-1:0] w_regs [NREGS];
    logic [NREGS-1:0] w_wr_dec;
    logic [NREGS-1:0] r_valid;
    logic             w_wr_ok;
    logic             w_byp_a;
    logic             w_byp_b;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;

    // A write is real only for an existing, writable register; bypass keys off the same test.
    assign w_wr_ok = bus.write
                     && ({1'b0, bus.writenum} < c_nregs)
                     && !((ZERO_REG != 0) && (bus.writenum == '0));
    assign w_byp_a = (BYPASS != 0) && w_wr_ok && (bus.writenum == bus.readnum_a);
    assign w_byp_b = (BYPASS != 0) && w_wr_ok && (bus.writenum == bus.readnum_b);

    generate
        for (genvar i = 0; i < NREGS; i++) begin : g_reg
            assign w_wr_dec[i] = w_wr_ok && (bus.writenum == AW'(i));
            if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
                assign w_regs[i] = '0;
            end else begin : g_cell
                rf_cell #(
                    .WIDTH       (WIDTH),
                    .RESET_VALUE (RESET_VALUE)
                ) u_cell (
                    .clk     (clk),
                    .reset   (reset),
                    .i_load  (w_wr_dec[i]),
                    .i_clear (bus.clear),
                    .i_d     (bus.data_in),
                    .o_q     (w_regs[i])
                );
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else begin
            r_valid <= (bus.clear ? '0 : r_valid) | w_wr_dec;
        end
    end

    // Unmatched (out-of-range) selects fall through to zero.
    always_comb begin
        w_rd_a = '0;
        w_rd_b = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (bus.readnum_a == AW'(i)) w_rd_a = w_regs[i];
            if (bus.readnum_b == AW'(i)) w_rd_b = w_regs[i];
        end
        if (w_byp_a) w_rd_a = bus.data_in;
        if (w_byp_b) w_rd_b = bus.data_in;
    end

    generate
        if (READ_LAT != 0) begin : g_rd_reg
            logic [WIDTH-1:0] r_out_a;
            logic [WIDTH-1:0] r_out_b;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_out_a <= '0;
                    r_out_b <= '0;
                end else begin
                    r_out_a <= w_rd_a;
                    r_out_b <= w_rd_b;
                end
            end
            assign bus.data_out_a = r_out_a;
            assign bus.data_out_b = r_out_b;
        end else begin : g_rd_comb
            assign bus.data_out_a = w_rd_a;
            assign bus.data_out_b = w_rd_b;
        end
    endgenerate

    assign bus.valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_regfile_2r1w.sv
//==============================================================================
// Module : tb_regfile_2r1w
// Brief  : Three parameterisations (default, READ_LAT=1/BYPASS=0, ZERO_REG=1/NREGS=6)
//          driven by one shared stimulus stream.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_regfile_2r1w;
    import rf_pkg::*;

    logic     clk = 1'b0;
    logic     reset = 1'b0;
    logic     write = 1'b0;
    logic     clear = 1'b0;
    reg_idx_t writenum = '0;
    reg_idx_t readnum_a = '0;
    reg_idx_t readnum_b = '0;
    word_t    data_in = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_2r1w_if #(.WIDTH(16), .NREGS(8)) if_a ();
    regfile_2r1w_if #(.WIDTH(16), .NREGS(8)) if_b ();
    regfile_2r1w_if #(.WIDTH(16), .NREGS(6)) if_c ();

    assign if_a.write = write;       assign if_b.write = write;       assign if_c.write = write;
    assign if_a.writenum = writenum; assign if_b.writenum = writenum; assign if_c.writenum = writenum;
    assign if_a.data_in = data_in;   assign if_b.data_in = data_in;   assign if_c.data_in = data_in;
    assign if_a.clear = clear;       assign if_b.clear = clear;       assign if_c.clear = clear;
    assign if_a.readnum_a = readnum_a; assign if_b.readnum_a = readnum_a; assign if_c.readnum_a = readnum_a;
    assign if_a.readnum_b = readnum_b; assign if_b.readnum_b = readnum_b; assign if_c.readnum_b = readnum_b;

    regfile_2r1w #(.WIDTH(16), .NREGS(8), .READ_LAT(0), .BYPASS(1), .ZERO_REG(0)) u_dut_a (
        .clk(clk), .reset(reset), .bus(if_a));
    regfile_2r1w #(.WIDTH(16), .NREGS(8), .READ_LAT(1), .BYPASS(0), .ZERO_REG(0)) u_dut_b (
        .clk(clk), .reset(reset), .bus(if_b));
    regfile_2r1w #(.WIDTH(16), .NREGS(6), .READ_LAT(0), .BYPASS(1), .ZERO_REG(1)) u_dut_c (
        .clk(clk), .reset(reset), .bus(if_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #10;
        checks++; if (if_a.valid !== 8'h00) begin failures++; $display("FAIL rst_valid_a: got %b expected %b", if_a.valid, 8'h00); end
        checks++; if (if_a.data_out_a !== 16'h0000) begin failures++; $display("FAIL rst_rd_a: got %h expected %h", if_a.data_out_a, 16'h0000); end
        checks++; if (if_b.data_out_b !== 16'h0000) begin failures++; $display("FAIL rst_rd_b: got %h expected %h", if_b.data_out_b, 16'h0000); end
        @(posedge clk); #2 reset = 1'b0;
        write = 1'b1; writenum = 3'd3; data_in = 16'hBEEF; readnum_a = 3'd3;
        tick();
        write = 1'b0;
        tick();
        checks++; if (if_a.data_out_a !== 16'hBEEF) begin failures++; $display("FAIL r3_a: got %h expected %h", if_a.data_out_a, 16'hBEEF); end
        checks++; if (if_b.data_out_a !== 16'hBEEF) begin failures++; $display("FAIL r3_b: got %h expected %h", if_b.data_out_a, 16'hBEEF); end
        checks++; if (if_a.valid !== 8'b0000_1000) begin failures++; $display("FAIL r3_valid: got %b expected %b", if_a.valid, 8'b0000_1000); end
        #2 reset = 1'b1;
        #1;
        checks++; if (if_a.data_out_a !== 16'h0000) begin failures++; $display("FAIL midrst_a: got %h expected %h", if_a.data_out_a, 16'h0000); end
        checks++; if (if_a.valid !== 8'h00) begin failures++; $display("FAIL midrst_valid: got %b expected %b", if_a.valid, 8'h00); end
        checks++; if (if_b.data_out_a !== 16'h0000) begin failures++; $display("FAIL midrst_b: got %h expected %h", if_b.data_out_a, 16'h0000); end
        checks++; if (if_c.valid !== 6'b000000) begin failures++; $display("FAIL midrst_valid_c: got %b expected %b", if_c.valid, 6'b000000); end
        @(posedge clk); #2 reset = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        write = 1'b1; writenum = 3'd5; data_in = 16'h1234;
        tick();
        writenum = 3'd2; data_in = 16'h00FF;
        tick();
        write = 1'b0; readnum_a = 3'd5; readnum_b = 3'd2;
        #1;
        checks++; if (if_a.data_out_a !== 16'h1234) begin failures++; $display("FAIL wr_a_a: got %h expected %h", if_a.data_out_a, 16'h1234); end
        checks++; if (if_a.data_out_b !== 16'h00FF) begin failures++; $display("FAIL wr_a_b: got %h expected %h", if_a.data_out_b, 16'h00FF); end
        checks++; if (if_a.valid !== 8'b0010_0100) begin failures++; $display("FAIL wr_valid: got %b expected %b", if_a.valid, 8'b0010_0100); end
        checks++; if (if_c.valid !== 6'b100100) begin failures++; $display("FAIL wr_valid_c: got %b expected %b", if_c.valid, 6'b100100); end
        tick();
        checks++; if (if_b.data_out_a !== 16'h1234) begin failures++; $display("FAIL wr_b_a: got %h expected %h", if_b.data_out_a, 16'h1234); end
        checks++; if (if_b.data_out_b !== 16'h00FF) begin failures++; $display("FAIL wr_b_b: got %h expected %h", if_b.data_out_b, 16'h00FF); end
    endtask

    task automatic test_bypass();
        write = 1'b1; writenum = 3'd4; data_in = 16'hAAAA;
        tick();
        data_in = 16'h5555; readnum_a = 3'd4;
        #1;
        checks++; if (if_a.data_out_a !== 16'h5555) begin failures++; $display("FAIL byp_a: got %h expected %h", if_a.data_out_a, 16'h5555); end
        checks++; if (if_c.data_out_a !== 16'h5555) begin failures++; $display("FAIL byp_c: got %h expected %h", if_c.data_out_a, 16'h5555); end
        tick();
        write = 1'b0;
        #1;
        checks++; if (if_b.data_out_a !== 16'hAAAA) begin failures++; $display("FAIL nobyp_old: got %h expected %h", if_b.data_out_a, 16'hAAAA); end
        tick();
        checks++; if (if_b.data_out_a !== 16'h5555) begin failures++; $display("FAIL nobyp_new: got %h expected %h", if_b.data_out_a, 16'h5555); end
    endtask

    task automatic test_clear_write();
        for (int i = 1; i < 8; i++) begin
            write = 1'b1; writenum = reg_idx_t'(i); data_in = 16'h1000 + 16'(i);
            tick();
        end
        clear = 1'b1; writenum = 3'd6; data_in = 16'h0042; readnum_a = 3'd6; readnum_b = 3'd1;
        #1;
        checks++; if (if_a.data_out_a !== 16'h0042) begin failures++; $display("FAIL clr_byp: got %h expected %h", if_a.data_out_a, 16'h0042); end
        checks++; if (if_a.data_out_b !== 16'h1001) begin failures++; $display("FAIL clr_pre: got %h expected %h", if_a.data_out_b, 16'h1001); end
        tick();
        clear = 1'b0; write = 1'b0;
        #1;
        checks++; if (if_b.data_out_a !== 16'h1006) begin failures++; $display("FAIL clr_b_a: got %h expected %h", if_b.data_out_a, 16'h1006); end
        checks++; if (if_b.data_out_b !== 16'h1001) begin failures++; $display("FAIL clr_b_b: got %h expected %h", if_b.data_out_b, 16'h1001); end
        checks++; if (if_a.valid !== 8'b0100_0000) begin failures++; $display("FAIL clr_valid: got %b expected %b", if_a.valid, 8'b0100_0000); end
        checks++; if (if_c.valid !== 6'b000000) begin failures++; $display("FAIL clr_valid_c: got %b expected %b", if_c.valid, 6'b000000); end
        checks++; if (if_c.data_out_b !== 16'h0000) begin failures++; $display("FAIL clr_c_b: got %h expected %h", if_c.data_out_b, 16'h0000); end
        for (int i = 0; i < 8; i++) begin
            readnum_a = reg_idx_t'(i);
            #1;
            checks++;
            if (if_a.data_out_a !== ((i == 6) ? 16'h0042 : 16'h0000)) begin
                failures++;
                $display("FAIL clr_r%0d: got %h expected %h", i, if_a.data_out_a, (i == 6) ? 16'h0042 : 16'h0000);
            end
        end
        tick();
    endtask

    task automatic test_zero_reg();
        write = 1'b1; writenum = 3'd0; data_in = 16'hFFFF; readnum_a = 3'd0;
        #1;
        checks++; if (if_c.data_out_a !== 16'h0000) begin failures++; $display("FAIL z_byp_c: got %h expected %h", if_c.data_out_a, 16'h0000); end
        checks++; if (if_a.data_out_a !== 16'hFFFF) begin failures++; $display("FAIL z_byp_a: got %h expected %h", if_a.data_out_a, 16'hFFFF); end
        tick();
        writenum = 3'd5; data_in = 16'h7777;
        tick();
        write = 1'b0; readnum_a = 3'd0; readnum_b = 3'd5;
        #1;
        checks++; if (if_c.data_out_a !== 16'h0000) begin failures++; $display("FAIL z_r0_c: got %h expected %h", if_c.data_out_a, 16'h0000); end
        checks++; if (if_c.data_out_b !== 16'h7777) begin failures++; $display("FAIL z_r5_c: got %h expected %h", if_c.data_out_b, 16'h7777); end
        checks++; if (if_c.valid !== 6'b100000) begin failures++; $display("FAIL z_valid_c: got %b expected %b", if_c.valid, 6'b100000); end
        checks++; if (if_a.valid !== 8'b0110_0001) begin failures++; $display("FAIL z_valid_a: got %b expected %b", if_a.valid, 8'b0110_0001); end
    endtask

    task automatic test_range();
        write = 1'b1; writenum = 3'd7; data_in = 16'h1357;
        tick();
        writenum = 3'd6; data_in = 16'h2468;
        tick();
        writenum = 3'd3; data_in = 16'h3C3C;
        tick();
        write = 1'b0; readnum_a = 3'd6;
        #1;
        checks++; if (if_c.data_out_a !== 16'h0000) begin failures++; $display("FAIL rng_r6_c: got %h expected %h", if_c.data_out_a, 16'h0000); end
        readnum_a = 3'd7;
        #1;
        checks++; if (if_c.data_out_a !== 16'h0000) begin failures++; $display("FAIL rng_r7_c: got %h expected %h", if_c.data_out_a, 16'h0000); end
        checks++; if (if_a.data_out_a !== 16'h1357) begin failures++; $display("FAIL rng_r7_a: got %h expected %h", if_a.data_out_a, 16'h1357); end
        readnum_a = 3'd3; readnum_b = 3'd3;
        #1;
        checks++; if (if_c.data_out_a !== 16'h3C3C) begin failures++; $display("FAIL same_c_a: got %h expected %h", if_c.data_out_a, 16'h3C3C); end
        checks++; if (if_c.data_out_b !== 16'h3C3C) begin failures++; $display("FAIL same_c_b: got %h expected %h", if_c.data_out_b, 16'h3C3C); end
        checks++; if (if_a.data_out_b !== 16'h3C3C) begin failures++; $display("FAIL same_a_b: got %h expected %h", if_a.data_out_b, 16'h3C3C); end
        checks++; if (if_c.valid !== 6'b101000) begin failures++; $display("FAIL rng_valid_c: got %b expected %b", if_c.valid, 6'b101000); end
        checks++; if (if_a.valid !== 8'b1110_1001) begin failures++; $display("FAIL rng_valid_a: got %b expected %b", if_a.valid, 8'b1110_1001); end
    endtask

    task automatic test_back_to_back();
        reg_idx_t sel [3];
        word_t    exp [3];
        sel = '{3'd5, 3'd6, 3'd7};
        exp = '{16'h7777, 16'h2468, 16'h1357};
        for (int i = 0; i < 3; i++) begin
            readnum_a = sel[i];
            tick();
            checks++;
            if (if_b.data_out_a !== exp[i]) begin
                failures++;
                $display("FAIL b2b_%0d: got %h expected %h", i, if_b.data_out_a, exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_clear_write();
        test_zero_reg();
        test_range();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
